// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 normalise/round/pack stage.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;

  // Bit positions inside the 28-bit extended mantissa
  localparam int CARRY  = 27;
  localparam int HIDDEN = 26;
  localparam int LSB    = 3;
  localparam int G      = 2;
  localparam int R      = 1;
  localparam int S      = 0;

  // Internal exponent width: wide enough for -64..+322 without wrap
  localparam int EXP_W = 11;

endpackage

// File: rtl/fp_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fp_lzc (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Scan upward so the most significant set bit decides the count
  always_comb begin
    count = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise / round-to-nearest-even / pack stage for binary32 sums.
// Optional macro FP_NORM_LZC_EN: single-cycle normalisation using a
// leading-zero counter and a barrel shifter; otherwise the mantissa is
// normalised one bit per cycle. Results and flags match in both builds.
module fp_norm_round
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [27:0] in_mant,
  input  logic        in_special,
  input  logic [31:0] in_special_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_LIM = EXP_W'(FP_EXP_MAX);

  state_t                  state, state_nxt;
  logic                    sign_q;
  logic signed [EXP_W-1:0] exp_q;
  logic [27:0]             mant_q;
  logic [31:0]             result_q;
  logic                    ovf_q, unf_q, inx_q;

  logic [27:0]             mant_sh;
  logic signed [EXP_W-1:0] exp_sh;
  logic                    shift_last;

  logic [24:0]             rnd;
  logic [23:0]             sig_c;
  logic signed [EXP_W-1:0] exp_rnd;
  logic [32:0]             packed_c;
  logic                    inx_c, unf_c;

  // Round-to-nearest-even on bits 27..3; result may carry into bit 27
  function automatic logic [24:0] rne_round(input logic [27:0] m);
    logic inc;
    inc = m[G] & (m[R] | m[S] | m[LSB]);
    return m[CARRY:LSB] + {24'b0, inc};
  endfunction

  // Pack sign/exponent/significand, saturating to infinity; MSB flags overflow
  function automatic logic [32:0] saturate_pack(input logic s,
                                                input logic signed [EXP_W-1:0] e,
                                                input logic [23:0] sig);
    if (e >= EXP_LIM)
      return {1'b1, s, FP_POS_INF[30:0]};
    else if (!sig[23])
      return {1'b0, s, 8'h00, sig[22:0]};
    else
      return {1'b0, s, e[7:0], sig[22:0]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

`ifdef FP_NORM_LZC_EN

  logic [4:0]              lzc;
  logic [5:0]              rsh;
  logic [4:0]              lsh;
  logic signed [EXP_W-1:0] lim;
  logic signed [EXP_W-1:0] rdist;

  // Right shift by n (n <= 28), folding every discarded bit into S
  function automatic logic [27:0] shr_sticky(input logic [27:0] m, input logic [5:0] n);
    logic [27:0] kept;
    logic [27:0] mask;
    kept = m >> n;
    mask = ~(28'hFFFFFFF << n);
    return {kept[27:1], kept[0] | (|(m & mask))};
  endfunction

  fp_lzc u_lzc (
    .value (mant_q[26:0]),
    .count (lzc)
  );

  // Whole normalisation in one step: subnormal right shift (which also
  // absorbs any carry), carry right shift, or left shift capped at exp 1
  always_comb begin
    mant_sh    = mant_q;
    exp_sh     = exp_q;
    shift_last = 1'b1;
    rsh        = '0;
    lsh        = '0;
    lim        = exp_q - EXP_ONE;
    rdist      = EXP_ONE - exp_q;
    if (exp_q < EXP_ONE) begin
      rsh     = (rdist > EXP_W'(28)) ? 6'd28 : rdist[5:0];
      mant_sh = shr_sticky(mant_q, rsh);
      exp_sh  = EXP_ONE;
    end else if (mant_q[CARRY]) begin
      mant_sh = shr_sticky(mant_q, 6'd1);
      exp_sh  = exp_q + EXP_ONE;
    end else begin
      lsh     = (lim < signed'({6'b0, lzc})) ? lim[4:0] : lzc;
      mant_sh = mant_q << lsh;
      exp_sh  = exp_q - signed'({6'b0, lsh});
    end
  end

`else

  // One normalisation action per cycle in priority order; flag the cycle
  // on which nothing is left to do
  always_comb begin
    mant_sh    = mant_q;
    exp_sh     = exp_q;
    shift_last = 1'b0;
    if (mant_q[CARRY] || (exp_q < EXP_ONE)) begin
      mant_sh = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
      exp_sh  = exp_q + EXP_ONE;
    end else if (!mant_q[HIDDEN] && (exp_q > EXP_ONE)) begin
      mant_sh = {mant_q[26:0], 1'b0};
      exp_sh  = exp_q - EXP_ONE;
    end else begin
      shift_last = 1'b1;
    end
  end

`endif

  // Rounding, post-round renormalisation and packing of the held operand
  always_comb begin
    rnd      = rne_round(mant_q);
    sig_c    = rnd[24] ? rnd[24:1] : rnd[23:0];
    exp_rnd  = exp_q + {{(EXP_W-1){1'b0}}, rnd[24]};
    packed_c = saturate_pack(sign_q, exp_rnd, sig_c);
    inx_c    = packed_c[32] | (|mant_q[G:S]);
    unf_c    = (packed_c[30:23] == 8'h00) & inx_c;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (in_special || (in_mant == 28'd0)) ? DONE : SHIFT;
      SHIFT: if (shift_last) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, normalisation steps and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_q <= in_sign;
            exp_q  <= {{(EXP_W-10){in_exp[9]}}, in_exp};
            mant_q <= in_mant;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inx_q  <= 1'b0;
            if (in_special)
              result_q <= in_special_word;
            else if (in_mant == 28'd0)
              result_q <= {in_sign, 31'b0};
          end
        end
        SHIFT: begin
          mant_q <= mant_sh;
          exp_q  <= exp_sh;
        end
        ROUND: begin
          result_q <= packed_c[31:0];
          ovf_q    <= packed_c[32];
          unf_q    <= unf_c;
          inx_q    <= inx_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed plan vectors, randomized
// operands against an exact-arithmetic RNE model, handshake and reset cases.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        in_special = 1'b0;
  logic [31:0] in_special_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  int vectors    = 0;
  int miscompares = 0;

  fp_norm_round dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_sign         (in_sign),
    .in_exp          (in_exp),
    .in_mant         (in_mant),
    .in_special      (in_special),
    .in_special_word (in_special_word),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .result          (result),
    .overflow        (overflow),
    .underflow       (underflow),
    .inexact         (inexact)
  );

  always #5 clk = ~clk;

  // Exact model: the operand is mant * 2^(exp-153); round that value to
  // binary32 with round-to-nearest-even, gradual underflow and overflow.
  task automatic ref_model(input logic s, input int e, input logic [27:0] m,
                           output logic [31:0] r, output logic [2:0] fl);
    int p, er, sh, n;
    longint q, rem, half;
    logic ovf, unf, inx;
    logic [7:0] fld;
    ovf = 0; unf = 0; inx = 0;
    if (m == 28'd0) begin
      r = {s, 31'b0}; fl = 3'b000;
      return;
    end
    p = 27;
    while (!m[p]) p--;
    er = e - 26 + p;
    if (er < 1) er = 1;
    sh = e - 3 - er;
    if (sh >= 0) begin
      q = longint'(m) << sh;
    end else begin
      n = -sh;
      if (n >= 40) begin
        q = 0; inx = 1;
      end else begin
        q    = longint'(m) >> n;
        rem  = longint'(m) & ((64'sd1 << n) - 1);
        half = 64'sd1 << (n - 1);
        inx  = (rem != 0);
        if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
      end
    end
    if (q >= (64'sd1 << 24)) begin
      q = q >> 1; er++;
    end
    if (er >= 255) begin
      r = {s, 8'hFF, 23'b0}; ovf = 1; inx = 1;
    end else begin
      fld = (q >= (64'sd1 << 23)) ? er[7:0] : 8'h00;
      r   = {s, fld, q[22:0]};
      unf = (fld == 8'h00) && inx;
    end
    fl = {ovf, unf, inx};
  endtask

  // Edges from accept until out_valid is seen
  function automatic int ref_latency(input int e, input logic [27:0] m, input logic sp);
    int lz, lim;
    logic found;
    if (sp || (m == 28'd0)) return 0;
`ifdef FP_NORM_LZC_EN
    lz = 0; lim = 0; found = 0;
    return 2 + lz + lim + int'(found);
`else
    if (e < 1) return 3 - e;
    if (m[27]) return 3;
    lz = 0; found = 0;
    for (int i = 26; i >= 0; i--) begin
      if (m[i]) found = 1;
      if (!found) lz++;
    end
    lim = e - 1;
    return 2 + ((lz < lim) ? lz : lim);
`endif
  endfunction

  // Present one operand (called #1 after a posedge), wait for the result,
  // and complete the handshake when out_ready is high
  task automatic run_op(input logic s, input int e, input logic [27:0] m,
                        input logic sp, input logic [31:0] w,
                        output logic [31:0] r, output logic [2:0] fl, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1; in_sign = s; in_exp = e[9:0]; in_mant = m;
    in_special = sp; in_special_word = w;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r  = result;
    fl = {overflow, underflow, inexact};
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_handshake: got %b required 10", {in_ready, out_valid});
    end
    vectors++;
    if ({result, overflow, underflow, inexact} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h/%b required 0/000", result, {overflow, underflow, inexact});
    end
  endtask

  typedef struct {
    logic        s;
    int          e;
    logic [27:0] m;
    logic        sp;
    logic [31:0] w;
    logic [31:0] r;
    logic [2:0]  fl;
  } dvec_t;

  task automatic test_directed();
    dvec_t tbl[11];
    logic [31:0] r;
    logic [2:0]  fl;
    int lat, elat;
    tbl[0]  = '{1'b0, 127, 28'h4000000, 1'b0, 32'h0, 32'h3F800000, 3'b000};
    tbl[1]  = '{1'b0, 130, 28'h0000008, 1'b0, 32'h0, 32'h35800000, 3'b000};
    tbl[2]  = '{1'b0, 127, 28'h4000004, 1'b0, 32'h0, 32'h3F800000, 3'b001};
    tbl[3]  = '{1'b0, 127, 28'h400000C, 1'b0, 32'h0, 32'h3F800002, 3'b001};
    tbl[4]  = '{1'b0, 254, 28'h8000000, 1'b0, 32'h0, 32'h7F800000, 3'b101};
    tbl[5]  = '{1'b0,   0, 28'h4000000, 1'b0, 32'h0, 32'h00400000, 3'b000};
    tbl[6]  = '{1'b0, -30, 28'h4000001, 1'b0, 32'h0, 32'h00000000, 3'b011};
    tbl[7]  = '{1'b1, 127, 28'h0000000, 1'b0, 32'h0, 32'h80000000, 3'b000};
    tbl[8]  = '{1'b0,  17, 28'h1234567, 1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000};
    tbl[9]  = '{1'b0,   1, 28'h3FFFFFC, 1'b0, 32'h0, 32'h00800000, 3'b001};
    tbl[10] = '{1'b0, 100, 28'hC000000, 1'b0, 32'h0, 32'h32C00000, 3'b000};
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].sp, tbl[i].w, r, fl, lat);
      elat = ref_latency(tbl[i].e, tbl[i].m, tbl[i].sp);
      vectors++;
      if (r !== tbl[i].r) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got %h required %h", i, r, tbl[i].r);
      end
      vectors++;
      if (fl !== tbl[i].fl) begin
        miscompares++;
        $display("FAIL directed_flags[%0d]: got ovf/unf/inx %b required %b", i, fl, tbl[i].fl);
      end
      vectors++;
      if (lat !== elat) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, elat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, er, w;
    logic [2:0]  fl, efl;
    logic [27:0] m;
    logic        s, sp;
    int e, lat, elat, kind;
    for (int i = 0; i < 200; i++) begin
      s    = 1'($urandom);
      kind = int'($urandom_range(0, 5));
      case (int'($urandom_range(0, 2)))
        0:       e = int'($urandom_range(0, 70)) - 64;
        1:       e = int'($urandom_range(245, 320));
        default: e = int'($urandom_range(0, 384)) - 64;
      endcase
      case (kind)
        0:       m = 28'($urandom);
        1:       m = {2'b01, 26'($urandom)};
        2:       m = 28'($urandom) >> $urandom_range(0, 27);
        3:       m = {1'b1, 27'($urandom)};
        4:       m = 28'($urandom_range(0, 15));
        default: m = {2'b01, 23'($urandom), 3'b100};
      endcase
      sp = ($urandom_range(0, 19) == 0);
      w  = $urandom;
      run_op(s, e, m, sp, w, r, fl, lat);
      if (sp) begin
        er = w; efl = 3'b000;
      end else begin
        ref_model(s, e, m, er, efl);
      end
      elat = ref_latency(e, m, sp);
      vectors++;
      if (r !== er) begin
        miscompares++;
        $display("FAIL random_result: exp %0d mant %h got %h required %h", e, m, r, er);
      end
      vectors++;
      if (fl !== efl) begin
        miscompares++;
        $display("FAIL random_flags: exp %0d mant %h got %b required %b", e, m, fl, efl);
      end
      vectors++;
      if (lat !== elat) begin
        miscompares++;
        $display("FAIL random_latency: exp %0d mant %h got %0d required %0d", e, m, lat, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, er;
    logic [2:0]  fl, efl;
    int lat;
    run_op(1'b1, 140, 28'h00ABCDE, 1'b0, 32'h0, r, fl, lat);
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_after_handshake: got ready/valid %b required 10", {in_ready, out_valid});
    end
    ref_model(1'b1, 140, 28'h00ABCDE, er, efl);
    vectors++;
    if (r !== er) begin
      miscompares++;
      $display("FAIL b2b_first: got %h required %h", r, er);
    end
    run_op(1'b0, -5, 28'h5555555, 1'b0, 32'h0, r, fl, lat);
    ref_model(1'b0, -5, 28'h5555555, er, efl);
    vectors++;
    if ({r, fl} !== {er, efl}) begin
      miscompares++;
      $display("FAIL b2b_second: got %h/%b required %h/%b", r, fl, er, efl);
    end
  endtask

  task automatic test_stall_special();
    logic [31:0] r;
    logic [2:0]  fl;
    int lat;
    out_ready = 0;
    run_op(1'b0, 0, 28'h0, 1'b1, 32'h7FC00000, r, fl, lat);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({result, out_valid, in_ready} !== {32'h7FC00000, 2'b10}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h valid %b ready %b required 7fc00000 1 0",
                 i, result, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_release: got ready/valid %b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r, er;
    logic [2:0]  fl, efl;
    int lat;
    logic saw_valid;
    in_valid = 1; in_sign = 0; in_exp = 10'd130; in_mant = 28'h0000008; in_special = 0;
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    #1;
    vectors++;
    if ({in_ready, out_valid, result, overflow, underflow, inexact} !== {2'b10, 35'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_shift: got ready %b valid %b result %h flags %b required 1 0 0 000",
               in_ready, out_valid, result, {overflow, underflow, inexact});
    end
    #2;
    rst = 0;
    saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1;
    end
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drop: got out_valid after abort %b required 0", saw_valid);
    end
    run_op(1'b1, 127, 28'h400000C, 1'b0, 32'h0, r, fl, lat);
    ref_model(1'b1, 127, 28'h400000C, er, efl);
    vectors++;
    if ({r, fl} !== {er, efl}) begin
      miscompares++;
      $display("FAIL reset_recover: got %h/%b required %h/%b", r, fl, er, efl);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_stall_special();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
